// File: rtl/imm_decode_buffer.sv
// imm_decode_buffer: decode-side pipeline buffer ahead of the sign extender.
// Accepts instructions over valid/ready, classifies each by LEGv8 format,
// extracts and extends the immediate, and holds results in a 2-entry skid
// buffer (main entry drives the outputs, skid entry absorbs one stall).
// Optional feature: define IMM_SHIFT_EN to shift B/CB immediates left by 2
// (byte offsets instead of word offsets).
module imm_decode_buffer #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [DATA_WIDTH-1:0]  in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0]  out_pc,
    output logic [DATA_WIDTH-1:0]  out_imm,
    output logic [2:0]             out_fmt
);

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_CB = 3'd3,
        FMT_B  = 3'd4
    } fmt_e;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  imm;
        fmt_e                   fmt;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   main_valid;
    logic   skid_valid;

    logic [DATA_WIDTH-1:0] b_ext;
    logic [DATA_WIDTH-1:0] cb_ext;
    logic [DATA_WIDTH-1:0] b_imm;
    logic [DATA_WIDTH-1:0] cb_imm;
    fmt_e                  dec_fmt;
    logic [DATA_WIDTH-1:0] dec_imm;

    logic accept;
    logic main_free;
    logic main_valid_nxt;
    logic skid_valid_nxt;

    // Branch offsets are word offsets; the optional shift turns them into byte offsets.
    assign b_ext  = {{(DATA_WIDTH-26){in_instr[25]}}, in_instr[25:0]};
    assign cb_ext = {{(DATA_WIDTH-19){in_instr[23]}}, in_instr[23:5]};
`ifdef IMM_SHIFT_EN
    assign b_imm  = {b_ext[DATA_WIDTH-3:0], 2'b00};
    assign cb_imm = {cb_ext[DATA_WIDTH-3:0], 2'b00};
`else
    assign b_imm  = b_ext;
    assign cb_imm = cb_ext;
`endif

    // First-match format classification and immediate extraction.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        dec_fmt = FMT_R;
        dec_imm = {{(DATA_WIDTH-6){1'b0}}, in_instr[15:10]};
        if (in_instr[30:26] == 5'b00101) begin
            dec_fmt = FMT_B;
            dec_imm = b_imm;
        end else if (in_instr[30:25] == 6'b011010 || in_instr[31:24] == 8'h54) begin
            dec_fmt = FMT_CB;
            dec_imm = cb_imm;
        end else if (in_instr[28:24] == 5'b10001) begin
            dec_fmt = FMT_I;
            dec_imm = {{(DATA_WIDTH-12){1'b0}}, in_instr[21:10]};
        end else if (in_instr[27] && !in_instr[25]) begin
            dec_fmt = FMT_D;
            dec_imm = {{(DATA_WIDTH-9){in_instr[20]}}, in_instr[20:12]};
        end
    end

    assign in_entry = '{instr: in_instr, pc: in_pc, imm: dec_imm, fmt: dec_fmt};

    // Handshake bookkeeping: main can take new data when empty or drained this cycle.
    always_comb begin
        accept    = in_valid && in_ready;
        main_free = !main_valid || out_ready;
        if (main_free) begin
            main_valid_nxt = skid_valid || accept;
            skid_valid_nxt = skid_valid && accept;
        end else begin
            main_valid_nxt = 1'b1;
            skid_valid_nxt = skid_valid || accept;
        end
    end

    // Valid bits, registered in_ready and main entry; flush overrides accept/consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            main_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready   <= !skid_valid_nxt;
            if (main_free) begin
                if (skid_valid) begin
                    main_q <= skid_q;
                end else if (accept) begin
                    main_q <= in_entry;
                end
            end
        end
    end

    // Skid payload: loaded whenever an accepted entry cannot go straight to main.
    always_ff @(posedge clk) begin
        // NOTE: skid payload has no reset; it is never observed unless skid_valid is set.
        if (!flush && accept && (skid_valid || !main_free)) begin
            skid_q <= in_entry;
        end
    end

    assign out_valid = main_valid;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_imm   = main_q.imm;
    assign out_fmt   = main_q.fmt;

endmodule

// File: tb/tb_imm_decode_buffer.sv
// Self-checking bench for imm_decode_buffer: a 2-deep FIFO model plus an
// arithmetic immediate decoder predict every output on every cycle, and a
// few hand-computed literals pin the model and the directed scenarios.
module tb_imm_decode_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    item_t q[$];
    logic [2:0]  exp_f;
    logic [63:0] exp_i;
    bit          room;

    localparam logic [31:0] LDUR = 32'hF85F8041;
    localparam logic [31:0] BNEG = 32'h17FFFFFF;
    localparam logic [31:0] ADDI = 32'h913FFC00;
    localparam logic [31:0] CBZ  = 32'hB4000043;

`ifdef IMM_SHIFT_EN
    localparam longint BR_MUL = 4;
    localparam logic [63:0] B_EXP  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] CB_EXP = 64'd8;
`else
    localparam longint BR_MUL = 1;
    localparam logic [63:0] B_EXP  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CB_EXP = 64'd2;
`endif

    imm_decode_buffer #(.INSTR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two's-complement value of an n-bit field held in the low bits of raw.
    function automatic longint sx(input longint unsigned raw, input int n);
        if (raw >= (64'd1 << (n - 1))) return longint'(raw) - (longint'(1) << n);
        return longint'(raw);
    endfunction

    // Reference decoder working on shifted/masked integers rather than bit slices.
    function automatic void ref_decode(input logic [31:0] w, output logic [2:0] f, output logic [63:0] imm);
        longint unsigned u = 64'(w);
        longint v;
        if (((u >> 26) & 64'h1F) == 64'h05) begin
            f = 3'd4;
            v = sx(u & 64'h3FF_FFFF, 26) * BR_MUL;
        end else if (((u >> 25) & 64'h3F) == 64'h1A || ((u >> 24) & 64'hFF) == 64'h54) begin
            f = 3'd3;
            v = sx((u >> 5) & 64'h7FFFF, 19) * BR_MUL;
        end else if (((u >> 24) & 64'h1F) == 64'h11) begin
            f = 3'd1;
            v = longint'((u >> 10) & 64'hFFF);
        end else if (((u >> 27) & 64'h1) == 64'h1 && ((u >> 25) & 64'h1) == 64'h0) begin
            f = 3'd2;
            v = sx((u >> 12) & 64'h1FF, 9);
        end else begin
            f = 3'd0;
            v = longint'((u >> 10) & 64'h3F);
        end
        imm = 64'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 5))
            0: w[30:26] = 5'b00101;
            1: w[31:24] = 8'h54;
            2: w[30:25] = 6'b011010;
            3: w[28:24] = 5'b10001;
            4: begin w[27] = 1'b1; w[25] = 1'b0; end
            default: ;
        endcase
        return w;
    endfunction

    // Behavioural model: a FIFO of capacity two; flush/reset empty it.
    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            room = (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && room) q.push_back('{in_instr, in_pc});
        end
    end

    // Compare process: every cycle outside reset, outputs against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                ref_decode(q[0].instr, exp_f, exp_i);
                check("out_instr", 64'(out_instr), 64'(q[0].instr));
                check("out_pc", out_pc, q[0].pc);
                check("out_imm", out_imm, exp_i);
                check("out_fmt", 64'(out_fmt), 64'(exp_f));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] pc, input logic ordy);
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
    endtask

    initial begin
        logic [2:0]  pf;
        logic [63:0] pi;

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 1'b0);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'd0);
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Pin the reference decoder against hand-computed values.
        ref_decode(LDUR, pf, pi);
        check("model_ldur_imm", pi, 64'hFFFF_FFFF_FFFF_FFF8);
        check("model_ldur_fmt", 64'(pf), 64'd2);
        ref_decode(BNEG, pf, pi);
        check("model_b_imm", pi, B_EXP);
        ref_decode(ADDI, pf, pi);
        check("model_addi_imm", pi, 64'h0000_0000_0000_0FFF);
        ref_decode(CBZ, pf, pi);
        check("model_cbz_imm", pi, CB_EXP);

        // Directed decode with the consumer always ready.
        drive(1'b1, LDUR, 64'h1000, 1'b1);
        tick();
        check("ldur_valid", 64'(out_valid), 64'd1);
        check("ldur_fmt", 64'(out_fmt), 64'd2);
        check("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_pc", out_pc, 64'h1000);
        drive(1'b1, BNEG, 64'h1004, 1'b1);
        tick();
        check("b_fmt", 64'(out_fmt), 64'd4);
        check("b_imm", out_imm, B_EXP);
        drive(1'b1, ADDI, 64'h1008, 1'b1);
        tick();
        check("addi_fmt", 64'(out_fmt), 64'd1);
        check("addi_imm", out_imm, 64'h0000_0000_0000_0FFF);
        drive(1'b1, CBZ, 64'h100C, 1'b1);
        tick();
        check("cbz_fmt", 64'(out_fmt), 64'd3);
        check("cbz_imm", out_imm, CB_EXP);
        drive(1'b0, 32'h0, 64'h0, 1'b1);
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: three offers with a stalled consumer.
        drive(1'b1, 32'h1111_1111, 64'h2000, 1'b0);
        tick();
        check("bp_ready1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h2222_2222, 64'h2004, 1'b0);
        tick();
        check("bp_ready2", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h3333_3333, 64'h2008, 1'b0);
        tick();
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_stable", 64'(out_instr), 64'h1111_1111);
        out_ready = 1'b1;
        tick();
        check("bp_second", 64'(out_instr), 64'h2222_2222);
        check("bp_reopen", 64'(in_ready), 64'd1);
        tick();
        check("bp_third", 64'(out_instr), 64'h3333_3333);
        in_valid = 1'b0;
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and a word on offer.
        drive(1'b1, 32'h4444_4444, 64'h3000, 1'b0);
        tick();
        drive(1'b1, 32'h5555_5555, 64'h3004, 1'b0);
        tick();
        check("fl_full", 64'(in_ready), 64'd0);
        flush    = 1'b1;
        in_instr = 32'h6666_6666;
        tick();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        // Flush while empty and ready: the offered word is still dropped.
        drive(1'b1, 32'h7777_7777, 64'h3008, 1'b1);
        tick();
        check("fl_drop", 64'(out_valid), 64'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 1'b1);
        tick();
        check("fl_quiet", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a stream.
        drive(1'b1, 32'h8888_8888, 64'h4000, 1'b1);
        tick();
        check("mr_pre", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_ready", 64'(in_ready), 64'd1);
        check("mr_instr", 64'(out_instr), 64'd0);
        check("mr_pc", out_pc, 64'd0);
        check("mr_imm", out_imm, 64'd0);
        check("mr_fmt", 64'(out_fmt), 64'd0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h9999_9999, 64'h5000, 1'b0);
        tick();
        check("mr_first_valid", 64'(out_valid), 64'd1);
        check("mr_first_instr", 64'(out_instr), 64'h9999_9999);
        drive(1'b0, 32'h0, 64'h0, 1'b1);
        tick();

        // Randomized traffic against the model, alternating stall-heavy and free-flowing phases.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0, 1'b1);
        tick();
        tick();
        tick();
        check("final_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
